rat_step_unit: RTL and testbench

Combinational move-arithmetic and direction-sequencing block for the intelligent-rat maze datapath. It adds a signed ±1 step to a 4-bit unsigned maze coordinate and flags moves that leave the 0..15 grid. It also holds the 2-bit direction counter that steps the controller through the four move directions. It sits between the coordinate registers and the maze memory, and reports `wall`-related range information to the controller.

---
 rtl/rat_step_unit.sv | 92 +++++++++
 tb/tb_rat_step_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rat_step_unit.sv
// -----------------------------------------------------------------------------
// rat_step_unit
//
// Move arithmetic and direction sequencing for the maze-solving datapath.
//
// The adder applies a +1 or -1 step to a 4-bit grid coordinate (0..15).
// The range check reports when that step would leave the grid.
// A 2-bit counter steps the controller through the four move directions.
//
// Ports
//   clk            rising-edge clock (counter only)
//   rst            asynchronous, active-low counter reset
//   add_a          unsigned coordinate operand (x or y)
//   add_b          step operand, two's complement (0001 = +1, 1111 = -1)
//   add_cin        adder carry-in (tied to 0 by the datapath)
//   add_sum        (add_a + add_b + add_cin) mod 16
//   add_cout       carry out of bit 3
//   out_of_range   the step leaves the 0..15 grid
//   rst_counter    synchronous clear of the direction counter
//   ld_counter     synchronous load of counter_ld_val
//   inc_counter    synchronous increment (mod 4)
//   counter_ld_val load value
//   counter_val    current direction index
//   co             high while the direction index is 3
// -----------------------------------------------------------------------------
module rat_step_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] add_a,
  input  logic [3:0] add_b,
  input  logic       add_cin,
  output logic [3:0] add_sum,
  output logic       add_cout,
  output logic       out_of_range,
  input  logic       rst_counter,
  input  logic       ld_counter,
  input  logic       inc_counter,
  input  logic [1:0] counter_ld_val,
  output logic [1:0] counter_val,
  output logic       co
);

  // 5-bit unsigned sum; bit 4 is the carry out of bit 3.
  function automatic logic [4:0] step_add(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       cin);
    return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  endfunction

  // add_b is a signed offset added to an unsigned coordinate. A positive
  // offset leaves the grid when it carries out; a negative offset (sign bit
  // set, so it looks like b+16 unsigned) leaves the grid when it does NOT
  // carry out, i.e. the true result went below zero.
  function automatic logic step_out_of_range(input logic       cout,
                                             input logic [3:0] b);
    return cout ^ b[3];
  endfunction

  logic [4:0] sum_full;
  logic [1:0] cnt_q;
  logic [1:0] cnt_nxt;

  always_comb begin
    sum_full     = step_add(add_a, add_b, add_cin);
    add_sum      = sum_full[3:0];
    add_cout     = sum_full[4];
    out_of_range = step_out_of_range(sum_full[4], add_b);
  end

  // Clear beats load beats increment; load never gets incremented on top.
  always_comb begin
    cnt_nxt = cnt_q;
    if (rst_counter)
      cnt_nxt = 2'd0;
    else if (ld_counter)
      cnt_nxt = counter_ld_val;
    else if (inc_counter)
      cnt_nxt = cnt_q + 2'd1;
  end

  // ---- direction counter register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= 2'd0;
    else
      cnt_q <= cnt_nxt;
  end

  assign counter_val = cnt_q;
  assign co          = (cnt_q == 2'd3);

endmodule

// File: tb/tb_rat_step_unit.sv
module tb_rat_step_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] add_a, add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout, out_of_range;
  logic       rst_counter, ld_counter, inc_counter;
  logic [1:0] counter_ld_val;
  logic [1:0] counter_val;
  logic       co;

  int checks = 0;
  int errors = 0;
  int mdl    = 0;   // reference direction index

  rat_step_unit dut (
    .clk(clk), .rst(rst),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .out_of_range(out_of_range),
    .rst_counter(rst_counter), .ld_counter(ld_counter), .inc_counter(inc_counter),
    .counter_ld_val(counter_ld_val), .counter_val(counter_val), .co(co)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       oor;
  } add_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: treat add_b as a signed offset and ask whether the true
  // coordinate lands outside 0..15.
  task automatic check_adder(input string tag, input int a, input int b, input int cin);
    int total, coord;
    total = a + b + cin;
    coord = a + ((b >= 8) ? b - 16 : b) + cin;
    add_a = a[3:0]; add_b = b[3:0]; add_cin = cin[0];
    #1;
    chk({tag, "_sum"},  {28'd0, add_sum},      total % 16);
    chk({tag, "_cout"}, {31'd0, add_cout},     total / 16);
    chk({tag, "_oor"},  {31'd0, out_of_range}, (coord < 0 || coord > 15) ? 1 : 0);
  endtask

  // Called right after a falling edge: drive, let a rising edge pass,
  // update the model, then check at the next falling edge.
  task automatic cyc(input logic rc, input logic ld, input logic inc, input logic [1:0] lv,
                     input string tag);
    rst_counter = rc; ld_counter = ld; inc_counter = inc; counter_ld_val = lv;
    @(posedge clk);
    if (rc)       mdl = 0;
    else if (ld)  mdl = lv;
    else if (inc) mdl = (mdl + 1) % 4;
    @(negedge clk);
    chk({tag, "_val"}, {30'd0, counter_val}, mdl);
    chk({tag, "_co"},  {31'd0, co},          (mdl == 3) ? 1 : 0);
  endtask

  add_vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd9,  4'd8,  1'b1, 4'd2,  1'b1, 1'b0};
    vecs[1] = '{4'd14, 4'd1,  1'b0, 4'd15, 1'b0, 1'b0};
    vecs[2] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b1};
    vecs[3] = '{4'd1,  4'd15, 1'b0, 4'd0,  1'b1, 1'b0};
    vecs[4] = '{4'd0,  4'd15, 1'b0, 4'd15, 1'b0, 1'b1};
    vecs[5] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b0};
    vecs[6] = '{4'd8,  4'd15, 1'b0, 4'd7,  1'b1, 1'b0};
    vecs[7] = '{4'd0,  4'd1,  1'b0, 4'd1,  1'b0, 1'b0};

    rst = 1'b0;
    rst_counter = 0; ld_counter = 0; inc_counter = 0; counter_ld_val = 0;
    add_a = 0; add_b = 0; add_cin = 0;
    #1;
    chk("reset_val", {30'd0, counter_val}, 0);
    chk("reset_co",  {31'd0, co},          0);

    // Hand-picked adder/range vectors.
    for (int i = 0; i < 8; i++) begin
      add_a = vecs[i].a; add_b = vecs[i].b; add_cin = vecs[i].cin;
      #1;
      chk($sformatf("vec%0d_sum", i),  {28'd0, add_sum},      {28'd0, vecs[i].sum});
      chk($sformatf("vec%0d_cout", i), {31'd0, add_cout},     {31'd0, vecs[i].cout});
      chk($sformatf("vec%0d_oor", i),  {31'd0, out_of_range}, {31'd0, vecs[i].oor});
    end

    // Exhaustive adder sweep against the arithmetic model.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          check_adder("sweep", a, b, c);

    // Release reset away from a rising edge.
    @(negedge clk);
    rst = 1'b1;
    mdl = 0;

    // Increment sequence 1,2,3,0,1.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 2'd0, $sformatf("inc%0d", i));

    // Load and priority.
    cyc(0, 1, 0, 2'd2, "load2");
    chk("load2_abs", {30'd0, counter_val}, 2);
    cyc(0, 1, 1, 2'd1, "ld_over_inc");
    chk("ld_over_inc_abs", {30'd0, counter_val}, 1);
    cyc(1, 1, 0, 2'd3, "clr_over_ld");
    chk("clr_over_ld_abs", {30'd0, counter_val}, 0);
    cyc(0, 1, 0, 2'd3, "load3");
    cyc(1, 1, 1, 2'd2, "clr_all");
    chk("clr_all_abs", {30'd0, counter_val}, 0);
    cyc(0, 0, 0, 2'd3, "hold");

    // Async reset between edges, with the counter at 3.
    cyc(0, 1, 0, 2'd3, "pre_arst");
    chk("pre_arst_co", {31'd0, co}, 1);
    inc_counter = 1; ld_counter = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst_val", {30'd0, counter_val}, 0);
    chk("arst_co",  {31'd0, co},          0);
    repeat (2) @(negedge clk);
    chk("arst_hold_val", {30'd0, counter_val}, 0);
    rst = 1'b1;
    mdl = 0;
    cyc(0, 0, 1, 2'd0, "post_arst");

    // Randomized control against the model.
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
          $urandom_range(0, 1), 2'($urandom_range(0, 3)), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
